// File: rtl/branch_pc_unit.sv
// Program counter owner with branch resolution: waits for the CON flop to settle,
// then adds the sign-extended displacement when the branch is taken.
module branch_pc_unit #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          CON_TIMEOUT = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR_bits,
    input  logic        br_start,
    input  logic        con_valid,
    input  logic        CON,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [31:0] BusMuxOut,
    output logic [31:0] PC_out,
    output logic        busy,
    output logic        taken,
    output logic        redirect,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, WAIT_CON, APPLY} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(CON_TIMEOUT - 1);

    state_t      state;
    logic [31:0] offset;
    logic [7:0]  wait_cnt;
    logic        pending;

    // Only the low 19 bits carry the displacement.
    logic unused_ir_upper;
    assign unused_ir_upper = ^IR_bits[31:19];

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            PC_out      <= PC_RESET;
            offset      <= 32'd0;
            wait_cnt    <= 8'd0;
            pending     <= 1'b0;
            taken       <= 1'b0;
            redirect    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_load)
                        PC_out <= BusMuxOut;
                    else if (pc_inc)
                        PC_out <= PC_out + 32'd1;
                    if (br_start) begin
                        offset      <= {{13{IR_bits[18]}}, IR_bits[18:0]};
                        timeout_err <= 1'b0;
                        wait_cnt    <= 8'd0;
                        state       <= WAIT_CON;
                    end
                end
                WAIT_CON: begin
                    // An absolute load abandons the branch; con_valid beats the timeout.
                    if (pc_load) begin
                        PC_out <= BusMuxOut;
                        state  <= IDLE;
                    end else if (con_valid) begin
                        pending <= CON;
                        state   <= APPLY;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == TIMEOUT_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                APPLY: begin
                    taken    <= pending;
                    redirect <= pending;
                    if (pending)
                        PC_out <= PC_out + offset;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, timeout corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_branch_pc_unit;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] IR_bits = 32'd0;
    logic        br_start = 1'b0;
    logic        con_valid = 1'b0;
    logic        CON = 1'b0;
    logic        pc_inc = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] BusMuxOut = 32'd0;
    logic [31:0] PC_out;
    logic        busy, taken, redirect, timeout_err;

    int errors = 0;
    int checks = 0;

    branch_pc_unit #(.PC_RESET(32'h0000_0000), .CON_TIMEOUT(TO)) dut (
        .clock(clock), .clear(clear), .IR_bits(IR_bits), .br_start(br_start),
        .con_valid(con_valid), .CON(CON), .pc_inc(pc_inc), .pc_load(pc_load),
        .BusMuxOut(BusMuxOut), .PC_out(PC_out), .busy(busy), .taken(taken),
        .redirect(redirect), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // Behavioural model: "phase" is 0 when free, 1 while awaiting CON, 2 on the resolve cycle.
    logic [31:0] m_pc = 32'd0;
    int          m_phase = 0;
    int          m_off = 0;
    int          m_waited = 0;
    bit          m_pend = 0, m_taken = 0, m_redir = 0, m_terr = 0;

    task automatic modelStep();
        if (clear) begin
            m_pc = 32'd0; m_phase = 0; m_off = 0; m_waited = 0;
            m_pend = 0; m_taken = 0; m_redir = 0; m_terr = 0;
        end else begin
            m_redir = 0;
            if (m_phase == 0) begin
                if (pc_load) m_pc = BusMuxOut;
                else if (pc_inc) m_pc = m_pc + 32'd1;
                if (br_start) begin
                    m_off = int'($signed(IR_bits[18:0]));
                    m_terr = 0; m_waited = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (pc_load) begin
                    m_pc = BusMuxOut; m_phase = 0;
                end else if (con_valid) begin
                    m_pend = CON; m_phase = 2;
                end else begin
                    m_waited++;
                    if (m_waited >= TO) begin m_terr = 1; m_phase = 0; end
                end
            end else begin
                m_taken = m_pend;
                if (m_pend) begin
                    m_pc = m_pc + 32'(m_off);
                    m_redir = 1;
                end
                m_phase = 0;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit clr, input bit br, input bit cv, input bit c,
                                 input bit inc, input bit ld, input logic [31:0] ir,
                                 input logic [31:0] bus);
        @(negedge clock);
        clear = clr; br_start = br; con_valid = cv; CON = c;
        pc_inc = inc; pc_load = ld; IR_bits = ir; BusMuxOut = bus;
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".pc"},       PC_out,              m_pc);
        cmp({tag, ".busy"},     {31'd0, busy},       {31'd0, m_phase != 0});
        cmp({tag, ".taken"},    {31'd0, taken},      {31'd0, m_taken});
        cmp({tag, ".redirect"}, {31'd0, redirect},   {31'd0, m_redir});
        cmp({tag, ".terr"},     {31'd0, timeout_err},{31'd0, m_terr});
    endtask

    typedef struct {
        bit clr, br, cv, c, inc, ld;
        logic [31:0] ir, bus;
        logic [31:0] e_pc;
        bit e_busy, e_taken, e_redir, e_terr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit clr, bit br, bit cv, bit c, bit inc, bit ld,
                                logic [31:0] ir, logic [31:0] bus, logic [31:0] pc,
                                bit bsy, bit tk, bit rd, bit te);
        vec_t v;
        v.clr = clr; v.br = br; v.cv = cv; v.c = c; v.inc = inc; v.ld = ld;
        v.ir = ir; v.bus = bus; v.e_pc = pc;
        v.e_busy = bsy; v.e_taken = tk; v.e_redir = rd; v.e_terr = te;
        return v;
    endfunction

    initial begin
        logic [31:0] pc_before;
        //            clr br cv c inc ld  ir          bus           pc           bsy tk rd te
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,      32'h10,       32'h10,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h20,     32'h0,        32'h10,       1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h10,       1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,      32'h0,        32'h10,       1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h30,       0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h30,       0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h7FFFF,  32'h0,        32'h30,       1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,      32'h0,        32'h30,       1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h30,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,      32'h40,       32'h40,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'hFFF7FFFF,32'h0,       32'h40,       1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,      32'h0,        32'h40,       1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h3F,       0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0,      32'h1234,     32'h1234,     0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,      32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,      32'h0,        32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h5,      32'h0,        32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,      32'h0,        32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,      32'h80,       32'h80,       0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h80,       0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h5,      32'h0,        32'h80,       1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,      32'h0,        32'h80,       1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h10,     32'h0,        32'h1,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,      32'h0,        32'h1,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h11,       0, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].br, vecs[i].cv, vecs[i].c,
                          vecs[i].inc, vecs[i].ld, vecs[i].ir, vecs[i].bus);
            cmp($sformatf("vec%0d.pc", i),       PC_out,               vecs[i].e_pc);
            cmp($sformatf("vec%0d.busy", i),     {31'd0, busy},        {31'd0, vecs[i].e_busy});
            cmp($sformatf("vec%0d.taken", i),    {31'd0, taken},       {31'd0, vecs[i].e_taken});
            cmp($sformatf("vec%0d.redirect", i), {31'd0, redirect},    {31'd0, vecs[i].e_redir});
            cmp($sformatf("vec%0d.terr", i),     {31'd0, timeout_err}, {31'd0, vecs[i].e_terr});
        end

        // Timeout: CON never arrives.
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 32'h500);
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h3, 32'h0);
        for (int i = 0; i < TO - 1; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
            cmp("to_wait.busy", {31'd0, busy}, 32'd1);
            cmp("to_wait.terr", {31'd0, timeout_err}, 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cmp("to_fire.busy", {31'd0, busy}, 32'd0);
        cmp("to_fire.terr", {31'd0, timeout_err}, 32'd1);
        cmp("to_fire.pc", PC_out, 32'h500);
        checkOutput("to_fire");
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cmp("to_sticky.terr", {31'd0, timeout_err}, 32'd1);

        // Next branch clears the error; con_valid on the final wait cycle still wins.
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h3, 32'h0);
        cmp("to_clr.terr", {31'd0, timeout_err}, 32'd0);
        for (int i = 0; i < TO - 1; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0, 32'h0);
        cmp("race.busy", {31'd0, busy}, 32'd1);
        cmp("race.terr", {31'd0, timeout_err}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cmp("race.pc", PC_out, 32'h503);
        cmp("race.redirect", {31'd0, redirect}, 32'd1);
        checkOutput("race");

        // Clear during the resolve cycle discards the pending branch.
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h40, 32'h0);
        applyStimulus(0, 0, 1, 1, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cmp("clr_apply.pc", PC_out, 32'h0);
        cmp("clr_apply.redirect", {31'd0, redirect}, 32'd0);
        checkOutput("clr_apply");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pc_before = m_pc;
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                          $urandom, $urandom);
            checkOutput($sformatf("rnd%0d", i));
            if (pc_before == 32'hFFFF_FFFF && i < 0) cmp("never", 32'd0, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Downstream consumer of the branch-condition flop (CON) in the datapath.
- Owns the program counter and sequences branch resolution:
  - a branch instruction is decoded;
  - the unit waits for CON to be evaluated;
  - it applies PC <- PC + sign-extended displacement when CON is set.
- Also handles plain PC increment and absolute PC load (jr/jal) from the bus.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after clear.
- CON_TIMEOUT, 8, max cycles to wait in WAIT_CON for con_valid before aborting (range 1..255).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- clear  in  1  synchronous active-high reset
- IR_bits  in  32  current instruction register; [18:0] = branch displacement C
- br_start  in  1  one-cycle pulse: branch decoded, IR_bits valid this cycle
- con_valid  in  1  one-cycle pulse: CON was updated on this edge and is stable
- CON  in  1  branch condition from the CON flop
- pc_inc  in  1  PC <- PC + 1
- pc_load  in  1  PC <- BusMuxOut
- BusMuxOut  in  32  datapath bus
- PC_out  out  32  current program counter
- busy  out  1  high in WAIT_CON and APPLY
- taken  out  1  result of last resolved branch, held until next resolution
- redirect  out  1  one-cycle pulse, high in the first cycle PC_out shows a taken-branch target
- timeout_err  out  1  sticky; set on WAIT_CON timeout; cleared by clear or next br_start

Behaviour:
- Reset (clear=1 at edge, overrides all inputs):
  - PC_out=PC_RESET; state=IDLE.
  - busy=0, taken=0, redirect=0, timeout_err=0; offset register=0, wait counter=0.
- States: IDLE, WAIT_CON, APPLY. Encoding is free.
- IDLE:
  - Priority: pc_load > pc_inc. pc_load: PC<=BusMuxOut. Else pc_inc: PC<=PC+1 (mod 2^32, wraps 32'hFFFF_FFFF -> 0).
  - br_start=1:
    - latch offset = {{13{IR_bits[18]}}, IR_bits[18:0]};
    - clear timeout_err and wait counter;
    - next state = WAIT_CON.
  - br_start together with pc_inc/pc_load: the PC update is still applied this edge; the branch target is computed from the updated PC.
- WAIT_CON:
  - pc_inc is ignored. br_start is ignored (no nesting).
  - pc_load=1 aborts the branch: PC<=BusMuxOut; next IDLE; taken unchanged; no redirect.
  - Else con_valid=1: latch CON into the taken-pending register; next APPLY.
  - Else the counter increments. When the counter reaches CON_TIMEOUT without con_valid: timeout_err<=1; next IDLE; PC unchanged.
  - con_valid in the same cycle the timeout would fire: con_valid wins.
- APPLY (exactly one cycle):
  - taken <= pending.
  - If pending=1: PC <= PC + offset (32-bit, wraps mod 2^32); redirect <= 1.
  - Else PC unchanged; redirect stays 0.
  - Next state IDLE. All inputs are ignored in APPLY except clear.
- Latency:
  - con_valid sampled at edge k.
  - New PC and taken are visible after edge k+1.
  - redirect is high from edge k+1 to edge k+2.
- redirect is registered and never high for more than one consecutive cycle.
- busy is a registered/Moore output equal to (state != IDLE).
- Clear mid-branch (WAIT_CON or APPLY): immediate return to reset values. No PC update from the pending branch.

Test Plan:
- clear for 2 cycles -> PC_out=0, busy=0, taken=0, redirect=0, timeout_err=0.
- PC=0x10; br_start with IR_bits[18:0]=0x00020; CON=1 and con_valid 2 cycles later:
  - busy=1 for 3 cycles;
  - one edge after con_valid: PC_out=0x30, taken=1, redirect one-cycle pulse.
- PC=0x30; br_start with IR_bits[18:0]=0x7FFFF (-1); con_valid with CON=0 -> PC_out stays 0x30, taken=0, redirect never high.
- PC=0x40; same branch with CON=1 -> PC_out=0x3F.
- br_start; no con_valid for 8 cycles (CON_TIMEOUT=8):
  - timeout_err=1, state back to IDLE, PC unchanged;
  - next br_start clears timeout_err.
- IDLE with pc_load and pc_inc both high, BusMuxOut=0x1234 -> PC=0x1234.
- PC=0xFFFF_FFFF with pc_inc -> PC=0.
- In WAIT_CON, pc_load with BusMuxOut=0x80 -> PC=0x80, busy=0 next cycle, no redirect.
- Clear asserted during APPLY -> PC=PC_RESET, redirect=0.
